// File: rtl/cdu_pkg.sv
// Shared types and widths for the CDU read-counter loop.
package cdu_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_WAIT,
    ST_STEP
  } state_t;

  localparam int LADDER_BITS = 7;
  localparam int CTR_BITS    = 16;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/read_ctr_ctl.sv
// Fine-error null-seeking loop: steps the read counter from the Schmitt-trigger
// outputs, drives the summing ladder and queues count pulses for the AGC.
module read_ctr_ctl
  import cdu_pkg::*;
#(
  parameter int SETTLE   = 8,
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 4,
  parameter int PEND_MAX = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                _TLF1H,
  input  logic                _TLF2H,
  input  logic                err_neg,
  input  logic                cdu_zero,
  input  logic                agc_ack,
  output logic                _D15,
  output logic                _D16,
  output logic                _D17,
  output logic                _D18,
  output logic                _D19,
  output logic                _D20,
  output logic                _D21,
  output logic [CTR_BITS-1:0] read_ctr,
  output logic                agc_req,
  output logic                agc_dir,
  output logic                nulled
);

  localparam int TMR_MAX = imax(SETTLE, imax(SLOW_DIV, FAST_DIV));
  localparam int TW      = imax(1, $clog2(TMR_MAX));
  localparam int PW      = imax(4, $clog2(PEND_MAX + 1) + 1);

  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] SLOW_LD   = TW'(SLOW_DIV - 1);
  localparam logic [TW-1:0] FAST_LD   = TW'(FAST_DIV - 1);

  localparam logic signed [PW-1:0] P_ONE    = PW'(1);
  localparam logic signed [PW-1:0] PEND_POS = PW'(PEND_MAX);
  localparam logic signed [PW-1:0] PEND_NEG = -PEND_POS;

  // Index 0: TLF1H, 1: TLF2H, 2: err_neg
  logic [2:0] async_in;
  logic [2:0] sync_out;
  logic       tlf1_s;
  logic       tlf2_s;
  logic       neg_s;

  assign async_in = {err_neg, _TLF2H, _TLF1H};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (async_in[gi]),
        .q     (sync_out[gi])
      );
    end
  endgenerate

  assign tlf1_s = sync_out[0];
  assign tlf2_s = sync_out[1];
  assign neg_s  = sync_out[2];

  state_t                  state_reg;
  logic [TW-1:0]           tmr_reg;
  logic                    dir_reg;
  logic                    nulled_reg;
  logic [CTR_BITS-1:0]     ctr_reg;
  logic [CTR_BITS-1:0]     ctr_next;
  logic signed [PW-1:0]    pend_reg;
  logic signed [PW-1:0]    pend_next;
  logic [LADDER_BITS-1:0]  ladder_n_reg;
  logic                    agc_req_reg;
  logic                    agc_dir_reg;
  logic                    stall;
  logic                    step_en;

  assign step_en = (state_reg == ST_STEP);
  assign stall   = (!dir_reg && (pend_reg == PEND_POS)) ||
                   ( dir_reg && (pend_reg == PEND_NEG));

  // Step and ack combine into one net change; cdu_zero wins over both.
  always_comb begin
    ctr_next  = ctr_reg;
    pend_next = pend_reg;
    if (step_en) begin
      ctr_next  = dir_reg ? (ctr_reg - 1'b1) : (ctr_reg + 1'b1);
      pend_next = dir_reg ? (pend_next - P_ONE) : (pend_next + P_ONE);
    end
    if (agc_ack && (pend_reg != '0)) begin
      pend_next = pend_reg[PW-1] ? (pend_next + P_ONE) : (pend_next - P_ONE);
    end
    if (cdu_zero) begin
      ctr_next  = '0;
      pend_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_SETTLE;
      tmr_reg    <= SETTLE_LD;
      dir_reg    <= 1'b0;
      nulled_reg <= 1'b0;
    end else if (cdu_zero) begin
      state_reg  <= ST_SETTLE;
      tmr_reg    <= SETTLE_LD;
      nulled_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          if (tmr_reg == '0) begin
            state_reg  <= ST_SAMPLE;
            nulled_reg <= !(tlf1_s || tlf2_s);
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (tlf2_s) begin
            tmr_reg    <= FAST_LD;
            dir_reg    <= neg_s;
            nulled_reg <= 1'b0;
            state_reg  <= ST_WAIT;
          end else if (tlf1_s) begin
            tmr_reg    <= SLOW_LD;
            dir_reg    <= neg_s;
            nulled_reg <= 1'b0;
            state_reg  <= ST_WAIT;
          end else begin
            nulled_reg <= 1'b1;
          end
        end
        ST_WAIT: begin
          // A full pending queue in our direction parks the divider at 0
          if (stall) begin
            tmr_reg <= '0;
          end else if (tmr_reg == '0) begin
            state_reg <= ST_STEP;
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        ST_STEP: begin
          state_reg <= ST_SETTLE;
          tmr_reg   <= SETTLE_LD;
        end
        default: begin
          state_reg <= ST_SETTLE;
          tmr_reg   <= SETTLE_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_reg      <= '0;
      pend_reg     <= '0;
      ladder_n_reg <= '1;
      agc_req_reg  <= 1'b0;
      agc_dir_reg  <= 1'b0;
    end else begin
      ctr_reg      <= ctr_next;
      pend_reg     <= pend_next;
      ladder_n_reg <= ~ctr_next[LADDER_BITS-1:0];
      agc_req_reg  <= (pend_next != '0);
      agc_dir_reg  <= pend_next[PW-1];
    end
  end

  assign read_ctr = ctr_reg;
  assign agc_req  = agc_req_reg;
  assign agc_dir  = agc_dir_reg;
  assign nulled   = nulled_reg;

  assign _D15 = ladder_n_reg[6];
  assign _D16 = ladder_n_reg[5];
  assign _D17 = ladder_n_reg[4];
  assign _D18 = ladder_n_reg[3];
  assign _D19 = ladder_n_reg[2];
  assign _D20 = ladder_n_reg[1];
  assign _D21 = ladder_n_reg[0];

endmodule

// File: tb/tb_read_ctr_ctl.sv
// Scoreboard bench for read_ctr_ctl: every expected counter change is queued
// before it is provoked and checked, with its spacing, when the DUT moves.
module tb_read_ctr_ctl;

  logic        clk;
  logic        rst_n;
  logic        tlf1;
  logic        tlf2;
  logic        err_neg;
  logic        cdu_zero;
  logic        agc_ack;
  logic        d15, d16, d17, d18, d19, d20, d21;
  logic [15:0] read_ctr;
  logic        agc_req;
  logic        agc_dir;
  logic        nulled;

  read_ctr_ctl #(
    .SETTLE   (4),
    .SLOW_DIV (16),
    .FAST_DIV (2),
    .PEND_MAX (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    ._TLF1H   (tlf1),
    ._TLF2H   (tlf2),
    .err_neg  (err_neg),
    .cdu_zero (cdu_zero),
    .agc_ack  (agc_ack),
    ._D15     (d15),
    ._D16     (d16),
    ._D17     (d17),
    ._D18     (d18),
    ._D19     (d19),
    ._D20     (d20),
    ._D21     (d21),
    .read_ctr (read_ctr),
    .agc_req  (agc_req),
    .agc_dir  (agc_dir),
    .nulled   (nulled)
  );

  typedef struct {
    logic [15:0] ctr;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] c, input int g);
    exp_t e;
    e.ctr = c;
    e.gap = g;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: every counter movement must match the head of the scoreboard.
  initial begin
    logic [15:0] prev_ctr;
    logic [6:0]  lad_got;
    logic [6:0]  lad_exp;
    int          last_cyc;
    exp_t        e;
    prev_ctr = 16'h0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (read_ctr !== prev_ctr)) begin
        if (sb.size() == 0) begin
          chk("unexp_step", read_ctr, prev_ctr);
        end else begin
          e = sb.pop_front();
          lad_got = {d15, d16, d17, d18, d19, d20, d21};
          lad_exp = ~e.ctr[6:0];
          chk("ctr", read_ctr, e.ctr);
          chk("ladder", lad_got, lad_exp);
          if (e.gap != 0) chk("gap", cyc - last_cyc, e.gap);
        end
        $display("step: read_ctr=%04h at cycle %0d (gap %0d)", read_ctr, cyc, cyc - last_cyc);
        prev_ctr = read_ctr;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    logic [6:0] lad;
    rst_n    = 1'b0;
    tlf1     = 1'b0;
    tlf2     = 1'b0;
    err_neg  = 1'b0;
    cdu_zero = 1'b0;
    agc_ack  = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    lad = {d15, d16, d17, d18, d19, d20, d21};
    chk("rst_ctr", read_ctr, 16'h0000);
    chk("rst_ladder", lad, 7'h7F);
    chk("rst_req", agc_req, 1'b0);
    chk("rst_dir", agc_dir, 1'b0);
    chk("rst_nulled", nulled, 1'b0);
    repeat (3) tick();
    chk("nulled_c4", nulled, 1'b0);
    tick();
    chk("nulled_c5", nulled, 1'b1);

    // Fast slew up, ack tied high
    push(16'h0001, 0);
    push(16'h0002, 8);
    push(16'h0003, 8);
    tlf2 = 1'b1; err_neg = 1'b0; agc_ack = 1'b1;
    wait_drain(100);
    tlf2 = 1'b0;
    chk("fast_ctr", read_ctr, 16'h0003);
    chk("fast_d20", d20, 1'b0);
    chk("fast_d21", d21, 1'b0);
    chk("fast_d19", d19, 1'b1);
    repeat (10) tick();
    chk("fast_nulled", nulled, 1'b1);
    chk("fast_req", agc_req, 1'b0);
    agc_ack = 1'b0;

    // Saturation in slow mode with no acks
    push(16'h0000, 0);
    cdu_zero = 1'b1;
    tick();
    cdu_zero = 1'b0;
    tlf1 = 1'b1; err_neg = 1'b0;
    push(16'h0001, 22);
    push(16'h0002, 22);
    push(16'h0003, 22);
    wait_drain(200);
    repeat (60) tick();
    chk("sat_ctr", read_ctr, 16'h0003);
    chk("sat_req", agc_req, 1'b1);
    chk("sat_dir", agc_dir, 1'b0);
    chk("sat_nulled", nulled, 1'b0);
    push(16'h0004, 0);
    agc_ack = 1'b1;
    tick();
    agc_ack = 1'b0;
    wait_drain(50);
    repeat (60) tick();
    chk("sat_ack_ctr", read_ctr, 16'h0004);
    chk("sat_ack_req", agc_req, 1'b1);
    // Draining unstalls the divider (already at 0), giving one last step
    push(16'h0005, 0);
    tlf1 = 1'b0;
    agc_ack = 1'b1;
    repeat (8) tick();
    agc_ack = 1'b0;
    wait_drain(20);
    chk("drain_req", agc_req, 1'b0);

    // Wrap below zero
    push(16'h0000, 0);
    cdu_zero = 1'b1;
    tick();
    cdu_zero = 1'b0;
    tlf2 = 1'b1; err_neg = 1'b1; agc_ack = 1'b1;
    push(16'hFFFF, 8);
    wait_drain(100);
    tlf2 = 1'b0;
    lad = {d15, d16, d17, d18, d19, d20, d21};
    chk("wrap_ctr", read_ctr, 16'hFFFF);
    chk("wrap_ladder", lad, 7'h00);
    repeat (10) tick();
    agc_ack = 1'b0;
    chk("wrap_req", agc_req, 1'b0);

    // Cancel: up step pending, then a down step removes it without ack
    push(16'h0000, 0);
    tlf2 = 1'b1; err_neg = 1'b0;
    wait_drain(100);
    err_neg = 1'b1;
    chk("cancel_req_pre", agc_req, 1'b1);
    chk("cancel_dir_pre", agc_dir, 1'b0);
    push(16'hFFFF, 8);
    wait_drain(50);
    tlf2 = 1'b0;
    chk("cancel_req", agc_req, 1'b0);
    chk("cancel_dir", agc_dir, 1'b0);
    repeat (10) tick();
    chk("cancel_req_hold", agc_req, 1'b0);

    // cdu_zero while in WAIT with two pulses pending
    err_neg = 1'b0; tlf1 = 1'b1;
    push(16'h0000, 0);
    push(16'h0001, 22);
    wait_drain(100);
    repeat (10) tick();
    chk("zm_req_pre", agc_req, 1'b1);
    chk("zm_dir_pre", agc_dir, 1'b0);
    push(16'h0000, 0);
    push(16'h0001, 22);
    cdu_zero = 1'b1;
    tick();
    cdu_zero = 1'b0;
    chk("zm_ctr", read_ctr, 16'h0000);
    chk("zm_req", agc_req, 1'b0);
    chk("zm_nulled", nulled, 1'b0);
    wait_drain(100);
    tlf1 = 1'b0;
    repeat (10) tick();
    chk("zm_end_req", agc_req, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/read_ctr_ctl.md
# read_ctr_ctl

Closed-loop controller for the fine-error summing ladder. It owns the 16-bit read counter and drives the active-low ladder switches `_D15`..`_D21` from the counter's low 7 bits. It samples the fine-error Schmitt-trigger outputs `_TLF1H` and `_TLF2H` and steps the counter toward null, slow or fast depending on error size. Every step is queued as an up or down count pulse for the AGC on a req/ack handshake.

## Interface
- `SETTLE`, default 8: cycles to wait after any ladder change before thresholds are trusted.
- `SLOW_DIV`, default 64: cycles per step when only `_TLF1H` is asserted.
- `FAST_DIV`, default 4: cycles per step when `_TLF2H` is asserted.
- `PEND_MAX`, default 7: maximum magnitude of unacknowledged AGC pulses.
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `_TLF1H`  in  1  fine threshold exceeded; asynchronous to `clk`.
- `_TLF2H`  in  1  coarse threshold exceeded; asynchronous to `clk`.
- `err_neg`  in  1  error phase. 1 means step down, 0 means step up. Asynchronous.
- `cdu_zero`  in  1  synchronous clear request.
- `agc_ack`  in  1  AGC accepted the current pulse.
- `_D15`..`_D21`  out  1 each  ladder switches, active-low; `_D15` is the MSB (counter bit 6), `_D21` is counter bit 0.
- `read_ctr`  out  16  read counter.
- `agc_req`  out  1  a count pulse is pending.
- `agc_dir`  out  1  1 = down, 0 = up; valid while `agc_req` is high.
- `nulled`  out  1  loop is at null.

## Operation
- **Input synchronisers.** `_TLF1H`, `_TLF2H` and `err_neg` each pass through a 2-flop synchroniser. All logic uses only the synchronised copies.
- **FSM states:** SETTLE, SAMPLE, WAIT, STEP.
- **SETTLE**
  - Load the timer with `SETTLE-1`.
  - Count down; at 0 go to SAMPLE.
- **SAMPLE**
  - Synchronised TLF2H high: latch fast mode, load divider with `FAST_DIV-1`, go to WAIT.
  - Else TLF1H high: latch slow mode, load divider with `SLOW_DIV-1`, go to WAIT.
  - Else: assert `nulled` and stay in SAMPLE.
  - Latch the direction from synchronised `err_neg` when leaving SAMPLE.
- **WAIT**
  - Count down; at 0 go to STEP.
  - Stall condition: `pending == +PEND_MAX` with latched direction up, or `pending == -PEND_MAX` with direction down.
  - While stalled, the divider holds at 0 and the FSM stays in WAIT.
- **STEP** (one cycle)
  - `read_ctr += 1` for up, `-= 1` for down, modulo 2^16 (0xFFFF+1 wraps to 0; 0-1 wraps to 0xFFFF).
  - `pending += 1` for up, `-= 1` for down.
  - Go to SETTLE.
- **Ladder drive.** `_Dn` is the inverse of the corresponding counter bit, registered from `read_ctr`.
- **Pending counter.** Signed, 4 bits minimum; must hold ±`PEND_MAX`.
  - `agc_req` is 1 when `pending != 0`.
  - `agc_dir` is 1 when `pending < 0`.
  - `agc_ack` while `agc_req` is high moves `pending` one toward 0.
  - `agc_ack` while `agc_req` is low is ignored.
- **Simultaneous STEP and ack.** Both apply in the same cycle, and the net change to `pending` is applied. A step opposite to the pending sign cancels one pending pulse.
- **`cdu_zero`.** Overrides everything in the same cycle: `read_ctr` = 0, `pending` = 0, state = SETTLE. Any in-flight req is withdrawn with no ack required.

## Timing
- **Reset values:**
  - `read_ctr` = 0.
  - `_D15`..`_D21` all 1 (switches open).
  - `agc_req` = 0, `agc_dir` = 0, `nulled` = 0.
  - `pending` = 0.
  - State = SETTLE with timer = `SETTLE-1`.
- **Registered outputs.** All outputs are registered. `read_ctr` and `_Dn` update on the clock edge that ends STEP.
- **Threshold-to-step latency** (from a threshold edge while in SAMPLE): 2 cycles sync + 1 cycle SAMPLE + N cycles WAIT + 1 cycle STEP, where N = `FAST_DIV` or `SLOW_DIV`.
- **Step period** when unstalled: `SETTLE + 1 + DIV + 1` cycles.
- **`agc_req` timing.** Rises the cycle after STEP. `agc_dir` is stable while `agc_req` is high unless a cancel crosses zero.
- **`nulled`** is high only during SAMPLE with no threshold asserted. It drops in the cycle SAMPLE is left.

## Structure
- **Shared package `cdu_pkg`:**
  - FSM state enum.
  - Ladder width constant `LADDER_BITS = 7`.
  - Counter width constant `CTR_BITS = 16`.
- **Sub-module `sync2`:** 2-flop synchroniser with async active-low reset to 0. Instantiated three times.
- **FSM, divider, counter and pending logic** stay in one module.

## Test plan
All scenarios use SETTLE=4, SLOW_DIV=16, FAST_DIV=2, PEND_MAX=3.

- **Reset:** hold `rst_n` low, then release → `read_ctr` = 0, all `_Dn` = 1, `agc_req` = 0; `nulled` = 1 at cycle 5 (no thresholds).
- **Fast slew:** `_TLF2H` = 1, `err_neg` = 0, `agc_ack` tied high → counter steps +1 every 8 cycles. After 3 steps: `read_ctr` = 3, `_D20` = 0, `_D21` = 0.
- **Saturation:** slow mode, `agc_ack` = 0 → `read_ctr` stops at 3, `pending` = 3, FSM stalls in WAIT. One ack pulse → exactly one further step.
- **Wrap:** `cdu_zero`, then down steps → `read_ctr` = 0xFFFF and all `_Dn` = 0 after the first step.
- **Cancel:** one up step pending, then `err_neg` = 1 → next step returns `pending` to 0 and `agc_req` drops with no ack.
- **Zero mid-request:** assert `cdu_zero` during WAIT with `pending` = 2 → next cycle `read_ctr` = 0, `agc_req` = 0, state = SETTLE.
